// File: rtl/regfile_ctrl.sv
// rtl/regfile_ctrl.sv - command sequencer for the 8x16 register file
// Accepts LDI/MOV/SWAP/CLR one at a time and sequences the single write port and single read port.
module regfile_ctrl #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs,
  input  logic [DW-1:0] cmd_imm,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] rf_data_in,
  output logic [AW-1:0] rf_writenum,
  output logic          rf_write,
  output logic [AW-1:0] rf_readnum,
  input  logic [DW-1:0] rf_data_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_SW_RD, S_SW_W1, S_SW_W2, S_CLR
  } state_t;

  localparam logic [1:0] OP_LDI  = 2'd0;
  localparam logic [1:0] OP_MOV  = 2'd1;
  localparam logic [1:0] OP_SWAP = 2'd2;

  state_t        state, state_nxt;
  logic [1:0]    op_q;
  logic [AW-1:0] rd_q, rs_q, cnt_q;
  logic [DW-1:0] imm_q, tmp_q;
  logic          accept, cnt_last;

  assign cmd_ready = (state == S_IDLE) && rst_n;
  assign busy      = (state != S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign cnt_last  = (cnt_q == {AW{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Command fields are captured once at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q  <= OP_LDI;
      rd_q  <= '0;
      rs_q  <= '0;
      imm_q <= '0;
      cnt_q <= '0;
      tmp_q <= '0;
      done  <= 1'b0;
    end else begin
      done <= (state == S_EXEC) || (state == S_SW_W2) || ((state == S_CLR) && cnt_last);
      if (accept) begin
        op_q  <= cmd_op;
        rd_q  <= cmd_rd;
        rs_q  <= cmd_rs;
        imm_q <= cmd_imm;
        cnt_q <= '0;
      end else if (state == S_CLR) begin
        cnt_q <= cnt_q + AW'(1);
      end
      if (state == S_SW_RD) tmp_q <= rf_data_out;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_LDI, OP_MOV: state_nxt = S_EXEC;
            OP_SWAP:        state_nxt = S_SW_RD;
            default:        state_nxt = S_CLR;
          endcase
        end
      end
      S_EXEC:  state_nxt = S_IDLE;
      S_SW_RD: state_nxt = S_SW_W1;
      S_SW_W1: state_nxt = S_SW_W2;
      S_SW_W2: state_nxt = S_IDLE;
      S_CLR:   if (cnt_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // MOV and SW_W1 pass rf_data_out straight back to the write port in the same cycle.
  always_comb begin
    rf_write    = 1'b0;
    rf_writenum = '0;
    rf_readnum  = '0;
    rf_data_in  = '0;
    case (state)
      S_EXEC: begin
        rf_write    = 1'b1;
        rf_writenum = rd_q;
        if (op_q == OP_MOV) begin
          rf_readnum = rs_q;
          rf_data_in = rf_data_out;
        end else begin
          rf_data_in = imm_q;
        end
      end
      S_SW_RD: rf_readnum = rd_q;
      S_SW_W1: begin
        rf_readnum  = rs_q;
        rf_write    = 1'b1;
        rf_writenum = rd_q;
        rf_data_in  = rf_data_out;
      end
      S_SW_W2: begin
        rf_write    = 1'b1;
        rf_writenum = rs_q;
        rf_data_in  = tmp_q;
      end
      S_CLR: begin
        rf_write    = 1'b1;
        rf_writenum = cnt_q;
      end
      default: ;
    endcase
    if (!rst_n) rf_write = 1'b0;
  end

endmodule

// File: doc/regfile_ctrl.md
# regfile_ctrl

Command sequencer for the 8×16 register file. It accepts one register-level command at a time over a valid/ready handshake and drives the register file's single write port and single combinational read port. Supported commands are load-immediate, move, swap, and clear-all. It sits between the instruction decoder and the register file, so the decoder never handles multi-cycle register sequencing.

## Interface
- `DW`, 16, data width; must match the register file word width.
- `AW`, 3, register address width; the register count is 2^AW = 8.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_op`  in  2  opcode: 00 LDI, 01 MOV, 10 SWAP, 11 CLR.
- `cmd_rd`  in  AW  destination register.
- `cmd_rs`  in  AW  source register; used by MOV and SWAP.
- `cmd_imm`  in  DW  immediate; used by LDI.
- `busy`  out  1  a command is in progress.
- `done`  out  1  one-cycle pulse when a command completes.
- `rf_data_in`  out  DW  register file write data.
- `rf_writenum`  out  AW  register file write address.
- `rf_write`  out  1  register file write enable.
- `rf_readnum`  out  AW  register file read address.
- `rf_data_out`  in  DW  register file read data; combinational from `rf_readnum`.

## Operation
- **Handshake.** A command is accepted on a rising edge where `cmd_valid && cmd_ready`.
  - On acceptance, the controller latches `op`, `rd`, `rs` and `imm` into internal registers.
  - All later cycles use only the latched fields; input changes after acceptance have no effect.
- **`cmd_ready`** equals (state == IDLE) && `rst_n`.
- **`busy`** equals (state != IDLE).
- **States:** IDLE, EXEC, SW_RD, SW_W1, SW_W2, CLR.
- **IDLE.** On acceptance, go to:
  - EXEC for LDI or MOV;
  - SW_RD for SWAP;
  - CLR for CLR, with the clear counter set to 0.
- **EXEC.**
  - `rf_write`=1, `rf_writenum`=rd.
  - LDI: `rf_data_in`=imm.
  - MOV: `rf_readnum`=rs and `rf_data_in`=`rf_data_out`.
  - Next state: IDLE.
- **SW_RD.** `rf_readnum`=rd; capture `rf_data_out` into tmp. Next: SW_W1.
- **SW_W1.** `rf_readnum`=rs, `rf_write`=1, `rf_writenum`=rd, `rf_data_in`=`rf_data_out`. Next: SW_W2.
- **SW_W2.** `rf_write`=1, `rf_writenum`=rs, `rf_data_in`=tmp. Next: IDLE.
- **CLR.**
  - `rf_write`=1, `rf_writenum`=counter, `rf_data_in`=0.
  - The counter increments each cycle.
  - When counter = 7, it wraps to 0 and the next state is IDLE.
- **Defaults.** In any state or cycle that does not drive them above:
  - `rf_write`=0;
  - `rf_data_in`=0, `rf_writenum`=0, `rf_readnum`=0.
- **`done`** is a registered flag. It is set on the edge that leaves the final write state (EXEC, SW_W2, or CLR with counter = 7) and is therefore high in the first IDLE cycle. It is 0 in every other cycle.
- **rd == rs.** MOV and SWAP still execute with the full cycle count; the register's value is unchanged.
- **Commands while busy.** `cmd_ready`=0, so `cmd_valid` is ignored; no queueing.
- **Reset.**
  - While `rst_n`=0, `rf_write` is forced to 0 combinationally.
  - At the next edge, state→IDLE, counter→0, tmp→0, `done`→0.
  - Reset mid-command aborts the command with no further writes. Writes completed before reset persist.
  - Reset values: `cmd_ready`=0 during reset and 1 after; `busy`=0, `done`=0, `rf_write`=0, all `rf_*` address and data outputs 0.

## Timing
- Accept edge T; the command's first state occupies cycle T+1.
- LDI/MOV: 1 write cycle at T+1; register updated at the end of T+1; `done` high and `cmd_ready`=1 in T+2.
- SWAP: cycles T+1 to T+3 (read, write rd, write rs); `done` in T+4.
- CLR: writes R0 to R7 in cycles T+1 to T+8; `done` in T+9.
- Back-to-back: a new command may be accepted in the `done` cycle. The minimum LDI-to-LDI issue interval is 2 cycles.
- The MOV and SW_W1 read-to-write path is combinational through the register file within one cycle.

## Test plan
- **Reset.** Hold `rst_n`=0 for 2 cycles with `cmd_valid`=1 → `cmd_ready`=0, `rf_write`=0, `busy`=0, `done`=0. After release, `cmd_ready`=1.
- **LDI.** LDI rd=3 imm=0xBEEF, accepted at T → `rf_write`=1 with `rf_writenum`=3 and `rf_data_in`=0xBEEF in T+1; `done` in T+2; R3 reads 0xBEEF.
- **MOV.** After the LDI, MOV rd=5 rs=3 → R5=0xBEEF; `done` 2 cycles after accept. Also MOV rd=rs=5 → R5 unchanged.
- **SWAP.** Load R1=0x1111 and R2=0x2222, then SWAP rd=1 rs=2 → write R1←0x2222 at T+2, write R2←0x1111 at T+3, `done` at T+4.
- **SWAP rd=rs.** SWAP rd=rs=4 with R4=0x00AA → R4 stays 0x00AA.
- **CLR.** Preload all registers nonzero, then CLR → 8 consecutive writes of 0 to addresses 0 through 7 in order; `done` at T+9.
- **Reset mid-CLR.** Drop `rst_n` after the write to R2 → R3 to R7 keep their preload values; state returns to IDLE.
- **Busy and back-to-back.** Hold `cmd_valid` high during a SWAP with changing fields → no second command accepted until the `done` cycle. A command held in the `done` cycle is accepted then.
